// File: rtl/mem_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : mem_bus_ctrl
//  Description : Bus sequencer between the ForthCPU core and the memory block.
//                Turns byte/word load/store requests (REQ/ACK handshake) into
//                a SETUP / STROBE / HOLD access on the memory port, maps byte
//                addresses onto the 16-bit lanes and zero-extends byte loads.
//                Optional feature macro: MISALIGNED_SPLIT_EN
//                  defined   -> misaligned word accesses become two byte cycles
//                  undefined -> misaligned word accesses end at once with ERR
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_bus_ctrl #(
    parameter int STROBE_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ,
    input  logic        WE,
    input  logic        BYTE,
    input  logic [15:0] CPU_ADDR,
    input  logic [15:0] WDATA,
    output logic [15:0] RDATA,
    output logic        ACK,
    output logic        BUSY,
    output logic        ERR,
    output logic [15:0] ADDR,
    output logic [15:0] DIN,
    input  logic [15:0] DOUT,
    output logic        RDN,
    output logic        WR0N,
    output logic        WR1N
);

`ifdef MISALIGNED_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // Strobe down-counter reload: the STROBE state lasts CNT_INIT+1 cycles.
    localparam logic [2:0] CNT_INIT = 3'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_HOLD   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [2:0]  cnt;
    logic        we_q;
    logic        byte_q;
    logic        split_q;
    logic        second_q;
    logic        err_q;
    logic [15:0] wdata_q;
    logic [7:0]  lo_buf;

    logic        misaligned;
    logic        reject;
    logic        both_lanes;

    // A word request on an odd address cannot use a single 16-bit cycle.
    assign misaligned = !BYTE && CPU_ADDR[0];
    // Without the split feature such a request is answered with ERR only.
    assign reject     = misaligned && !SPLIT_EN;
    // Only an aligned word access drives both byte lanes at once.
    assign both_lanes = !byte_q && !split_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and strobe/handshake outputs.
    always_comb begin
        state_nxt = state;
        RDN       = 1'b1;
        WR0N      = 1'b1;
        WR1N      = 1'b1;
        ACK       = 1'b0;
        ERR       = 1'b0;
        BUSY      = (state != ST_IDLE);
        case (state)
            ST_IDLE: begin
                if (REQ) begin
                    state_nxt = reject ? ST_DONE : ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                if (!we_q) begin
                    RDN = 1'b0;
                end else if (both_lanes) begin
                    WR0N = 1'b0;
                    WR1N = 1'b0;
                end else if (ADDR[0]) begin
                    WR1N = 1'b0;
                end else begin
                    WR0N = 1'b0;
                end
                if (cnt == 3'd0) begin
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                state_nxt = (split_q && !second_q) ? ST_SETUP : ST_DONE;
            end
            ST_DONE: begin
                ACK       = 1'b1;
                ERR       = err_q;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request latches, memory address/data registers, strobe counter and load capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ADDR     <= 16'h0000;
            DIN      <= 16'h0000;
            RDATA    <= 16'h0000;
            cnt      <= 3'd0;
            we_q     <= 1'b0;
            byte_q   <= 1'b0;
            split_q  <= 1'b0;
            second_q <= 1'b0;
            err_q    <= 1'b0;
            wdata_q  <= 16'h0000;
            lo_buf   <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (REQ) begin
                        we_q     <= WE;
                        byte_q   <= BYTE;
                        wdata_q  <= WDATA;
                        second_q <= 1'b0;
                        split_q  <= misaligned && SPLIT_EN;
                        err_q    <= reject;
                        // A rejected request never reaches the bus, so leave it untouched.
                        if (!reject) begin
                            ADDR <= CPU_ADDR;
                            DIN  <= (BYTE || misaligned) ? {WDATA[7:0], WDATA[7:0]} : WDATA;
                        end
                    end
                end
                ST_SETUP: begin
                    cnt <= CNT_INIT;
                end
                ST_STROBE: begin
                    if (cnt != 3'd0) begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (!we_q) begin
                        if (split_q) begin
                            // First half sits in the high lane; RDATA only changes once both halves are in.
                            if (!second_q) begin
                                lo_buf <= DOUT[15:8];
                            end else begin
                                RDATA <= {DOUT[7:0], lo_buf};
                            end
                        end else if (byte_q) begin
                            RDATA <= {8'h00, ADDR[0] ? DOUT[15:8] : DOUT[7:0]};
                        end else begin
                            RDATA <= DOUT;
                        end
                    end
                    if (split_q && !second_q) begin
                        second_q <= 1'b1;
                        ADDR     <= ADDR + 16'd1;
                        DIN      <= {wdata_q[15:8], wdata_q[15:8]};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_bus_ctrl
//  Description : Self-checking bench for mem_bus_ctrl with a small ROM/RAM
//                memory model and an ACK-driven scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_bus_ctrl;

    localparam int S     = 1;
    localparam int LAT   = 3 + S;
    localparam int LAT_S = 5 + 2 * S;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        REQ = 1'b0;
    logic        WE = 1'b0;
    logic        BYTE = 1'b0;
    logic [15:0] CPU_ADDR = 16'h0000;
    logic [15:0] WDATA = 16'h0000;
    logic [15:0] RDATA;
    logic        ACK;
    logic        BUSY;
    logic        ERR;
    logic [15:0] ADDR;
    logic [15:0] DIN;
    logic [15:0] DOUT = 16'h0000;
    logic        RDN;
    logic        WR0N;
    logic        WR1N;

    always #5 CLK = ~CLK;

    mem_bus_ctrl #(.STROBE_CYCLES(S)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .BYTE(BYTE),
        .CPU_ADDR(CPU_ADDR), .WDATA(WDATA), .RDATA(RDATA), .ACK(ACK),
        .BUSY(BUSY), .ERR(ERR), .ADDR(ADDR), .DIN(DIN), .DOUT(DOUT),
        .RDN(RDN), .WR0N(WR0N), .WR1N(WR1N)
    );

    // Memory model: 0x0000-0x0FFF is ROM (word 0 = 0x1000), the rest is RAM.
    logic [15:0] ram [0:32767];

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        return (a[15:1] == 15'd0) ? 16'h1000 : 16'h0000;
    endfunction

    always @(posedge CLK) begin
        if (!RDN) DOUT <= (ADDR < 16'h1000) ? rom_word(ADDR) : ram[ADDR[15:1]];
        if (ADDR >= 16'h1000) begin
            if (!WR0N) ram[ADDR[15:1]][7:0]  <= DIN[7:0];
            if (!WR1N) ram[ADDR[15:1]][15:8] <= DIN[15:8];
        end
    end

    typedef struct {
        logic        chk;
        logic [15:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drive_cyc = 0;
    int acks = 0;
    int rdn_n = 0, wr0_n = 0, wr1_n = 0, both_n = 0, overlap_n = 0;
    logic [15:0] wr0_addr = 16'h0000;
    logic [15:0] wr1_addr = 16'h0000;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    always @(posedge CLK) cyc <= cyc + 1;

    // Strobe activity counters.
    always @(negedge CLK) begin
        if (!RDN) rdn_n++;
        if (!WR0N) begin wr0_n++; wr0_addr = ADDR; end
        if (!WR1N) begin wr1_n++; wr1_addr = ADDR; end
        if (!WR0N && !WR1N) both_n++;
        if (!RDN && (!WR0N || !WR1N)) overlap_n++;
    end

    // Scoreboard monitor: every ACK consumes one expected response.
    always @(negedge CLK) begin
        if (ACK === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got ACK=1 expected no ACK");
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ack_err", {31'd0, ERR}, {31'd0, e.err});
                check("ack_latency", cyc - drive_cyc, e.lat);
                if (e.chk) check("ack_rdata", {16'd0, RDATA}, {16'd0, e.rdata});
            end
            acks++;
        end
    end

    task automatic access(input string nm, input logic we, input logic by,
                          input logic [15:0] a, input logic [15:0] wd,
                          input logic chk, input logic [15:0] exp_rd, input logic exp_err,
                          input int lat, input int n_rdn, input int n_wr0,
                          input int n_wr1, input int n_both);
        int r0, w0, w1, b0, a0;
        bit done;
        exp_t e;
        e.chk = chk; e.rdata = exp_rd; e.err = exp_err; e.lat = lat;
        exp_q.push_back(e);
        @(negedge CLK);
        r0 = rdn_n; w0 = wr0_n; w1 = wr1_n; b0 = both_n; a0 = acks;
        drive_cyc = cyc;
        REQ = 1'b1; WE = we; BYTE = by; CPU_ADDR = a; WDATA = wd;
        @(posedge CLK);
        #1 REQ = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge CLK);
            #1;
            if (acks != a0) begin done = 1'b1; break; end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ACK expected ACK within 60 cycles", nm);
            exp_q.delete();
        end
        check({nm, "_rdn"}, rdn_n - r0, n_rdn);
        check({nm, "_wr0"}, wr0_n - w0, n_wr0);
        check({nm, "_wr1"}, wr1_n - w1, n_wr1);
        check({nm, "_both"}, both_n - b0, n_both);
    endtask

    initial begin
        // Reset state.
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("rst_rdn", {31'd0, RDN}, 1);
        check("rst_wr0n", {31'd0, WR0N}, 1);
        check("rst_wr1n", {31'd0, WR1N}, 1);
        check("rst_ack", {31'd0, ACK}, 0);
        check("rst_busy", {31'd0, BUSY}, 0);
        check("rst_err", {31'd0, ERR}, 0);
        check("rst_rdata", {16'd0, RDATA}, 0);
        check("rst_addr", {16'd0, ADDR}, 0);
        check("rst_din", {16'd0, DIN}, 0);
        RESET = 1'b0;

        // ROM load, ignored ROM store, reload.
        access("ld_rom",  0, 0, 16'h0000, 16'h0000, 1, 16'h1000, 0, LAT, S, 0, 0, 0);
        access("st_rom",  1, 0, 16'h0000, 16'hABCD, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("ld_rom2", 0, 0, 16'h0000, 16'h0000, 1, 16'h1000, 0, LAT, S, 0, 0, 0);

        // Aligned RAM word store / load.
        access("st_2000", 1, 0, 16'h2000, 16'hABCD, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("ld_2000", 0, 0, 16'h2000, 16'h0000, 1, 16'hABCD, 0, LAT, S, 0, 0, 0);

        // Byte stores into each lane, byte loads zero-extended.
        access("st_3000", 1, 0, 16'h3000, 16'hDCBA, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("bst_lo",  1, 1, 16'h3000, 16'h55EE, 0, 16'h0000, 0, LAT, 0, S, 0, 0);
        access("ld_lo",   0, 0, 16'h3000, 16'h0000, 1, 16'hDCEE, 0, LAT, S, 0, 0, 0);
        access("st_3000b",1, 0, 16'h3000, 16'hDCBA, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("bst_hi",  1, 1, 16'h3001, 16'h11EE, 0, 16'h0000, 0, LAT, 0, 0, S, 0);
        access("ld_hi",   0, 0, 16'h3000, 16'h0000, 1, 16'hEEBA, 0, LAT, S, 0, 0, 0);
        access("bld_hi",  0, 1, 16'h3001, 16'h0000, 1, 16'h00EE, 0, LAT, S, 0, 0, 0);
        access("bld_lo",  0, 1, 16'h3000, 16'h0000, 1, 16'h00BA, 0, LAT, S, 0, 0, 0);

`ifdef MISALIGNED_SPLIT_EN
        // Misaligned word accesses split into two byte cycles.
        access("st_3002", 1, 0, 16'h3002, 16'h0000, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("st_3000c",1, 0, 16'h3000, 16'hDCBA, 0, 16'h0000, 0, LAT, 0, S, S, S);
        access("st_mis",  1, 0, 16'h3001, 16'h1234, 0, 16'h0000, 0, LAT_S, 0, S, S, 0);
        check("st_mis_wr1_addr", {16'd0, wr1_addr}, 32'h3001);
        check("st_mis_wr0_addr", {16'd0, wr0_addr}, 32'h3002);
        access("ld_m3000",0, 0, 16'h3000, 16'h0000, 1, 16'h34BA, 0, LAT, S, 0, 0, 0);
        access("ld_m3002",0, 0, 16'h3002, 16'h0000, 1, 16'h0012, 0, LAT, S, 0, 0, 0);
        access("ld_mis",  0, 0, 16'h3001, 16'h0000, 1, 16'h1234, 0, LAT_S, 2 * S, 0, 0, 0);
        // Address wrap: second half of 0xFFFF lands on ROM word 0.
        access("st_wrap", 1, 0, 16'hFFFF, 16'h5678, 0, 16'h0000, 0, LAT_S, 0, S, S, 0);
        check("st_wrap_wr0_addr", {16'd0, wr0_addr}, 32'h0000);
        access("ld_wrap", 0, 0, 16'hFFFF, 16'h0000, 1, 16'h0078, 0, LAT_S, 2 * S, 0, 0, 0);
`else
        // Misaligned word accesses rejected with ERR, RDATA unchanged.
        access("ld_mis",  0, 0, 16'h3001, 16'h0000, 1, 16'h00BA, 1, 1, 0, 0, 0, 0);
        access("st_mis",  1, 0, 16'h3001, 16'h1234, 1, 16'h00BA, 1, 1, 0, 0, 0, 0);
`endif

        // Reset during the strobe of a store.
        @(negedge CLK);
        REQ = 1'b1; WE = 1'b1; BYTE = 1'b0; CPU_ADDR = 16'h4000; WDATA = 16'h5A5A;
        @(posedge CLK);
        #1 REQ = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (WR0N === 1'b0) break;
        end
        check("abort_strobe_seen", {31'd0, WR0N}, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        check("abort_wr0n", {31'd0, WR0N}, 1);
        check("abort_wr1n", {31'd0, WR1N}, 1);
        check("abort_busy", {31'd0, BUSY}, 0);
        check("abort_ack", {31'd0, ACK}, 0);
        check("abort_rdata", {16'd0, RDATA}, 0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("abort_no_ack", {31'd0, ACK}, 0);
        end
        access("ld_after", 0, 0, 16'h2000, 16'h0000, 1, 16'hABCD, 0, LAT, S, 0, 0, 0);

        check("strobe_overlap", overlap_n, 0);
        check("scoreboard_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Bus sequencer between the ForthCPU core and the `memory` block. It accepts byte or word load/store requests from the core over a REQ/ACK handshake and drives the memory's ADDR/DIN/RDN/WR0N/WR1N with a fixed setup/strobe/hold sequence. It maps byte addresses onto the 16-bit lanes, zero-extends byte reads, and splits misaligned word accesses into two byte cycles when that feature is compiled in.

## Interface
Parameters:
- STROBE_CYCLES, 1, cycles RDN/WRxN are held low per access (1..7)

Ports:
- CLK  in  1  system clock; all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- REQ  in  1  core request; sampled only in IDLE
- WE  in  1  1 = store, 0 = load; latched with REQ
- BYTE  in  1  1 = byte access, 0 = word access
- CPU_ADDR  in  16  byte address
- WDATA  in  16  store data; the byte store uses [7:0]
- RDATA  out  16  load result; valid while ACK=1, held until the next load completes
- ACK  out  1  one-cycle completion pulse
- BUSY  out  1  high from the cycle after REQ acceptance through the ACK cycle
- ERR  out  1  misaligned-word error; coincident with ACK (only without the macro)
- ADDR  out  16  memory byte address
- DIN  out  16  memory write data
- DOUT  in  16  memory read data; valid the cycle after the strobe
- RDN, WR0N, WR1N  out  1  active-low read strobe and low/high byte write strobes

## Operation
- Little-endian. Even address = low lane (WR0N, DOUT[7:0]). Odd address = high lane (WR1N, DOUT[15:8]).
- States: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE: when REQ=1, latch WE, BYTE, CPU_ADDR and WDATA, then go to SETUP.
- SETUP: ADDR and DIN are driven from the latches; all strobes are high; go to STROBE.
- STROBE: assert RDN (load) or the selected WRxN (store) for STROBE_CYCLES cycles, counted by a down-counter; then go to HOLD.
- HOLD: all strobes are high; ADDR and DIN are unchanged. On a load, capture the selected lane(s) of DOUT. If a second half is pending, go to SETUP with address+1; otherwise go to DONE.
- DONE: ACK=1 and BUSY=1 for one cycle; return to IDLE.
- Aligned word access: DIN=WDATA; both WR0N and WR1N are driven together; RDATA=DOUT.
- Byte store: DIN={WDATA[7:0],WDATA[7:0]}; only the lane strobe is asserted.
- Byte load: RDATA={8'h00, lane}.
- Misaligned word access (BYTE=0, CPU_ADDR[0]=1), with the macro:
  - First half: the byte at A (high lane) uses WDATA[7:0] and loads into RDATA[7:0].
  - Second half: the byte at A+1 (low lane of the next word) uses WDATA[15:8] and loads into RDATA[15:8].
- Address arithmetic is 16-bit: 0xFFFF+1 wraps to 0x0000.
- At most one strobe state is active at a time; RDN and WRxN are never low together.
- REQ outside IDLE is ignored. The core must drop REQ in the ACK cycle or be accepted again on the next IDLE cycle.
- Writes to ROM addresses are issued normally; the memory block ignores them.

## Timing
- Reset values: RDN=WR0N=WR1N=1, ACK=0, BUSY=0, ERR=0, RDATA=0, ADDR=0, DIN=0; state IDLE.
- RESET mid-access: on the next edge all strobes go high and the FSM enters IDLE; no ACK is issued.
- Latency is measured from the edge that samples REQ to the ACK cycle, where S = STROBE_CYCLES:
  - aligned access: 3+S cycles (4 when S=1)
  - split access: 5+2S cycles (7 when S=1)
  - error path: 1 cycle
- Back-to-back: a new REQ is accepted in the IDLE cycle immediately after DONE. Throughput is one aligned access per 4+S cycles.
- ADDR and DIN are stable for the whole SETUP..HOLD window, with at least one cycle of setup and one of hold around each strobe.

## Configuration
- MISALIGNED_SPLIT_EN defined: a misaligned word access is split into two byte cycles as described above; ERR is tied to 0.
- MISALIGNED_SPLIT_EN undefined: a misaligned word access goes IDLE→DONE with no strobes; ACK=1 and ERR=1 for one cycle and RDATA is unchanged. Aligned and byte accesses are identical in both builds.

## Test plan
- Word load 0x0000 (ROM holds 0x1000), S=1 → RDN low for exactly 1 cycle; ACK 4 cycles after REQ; RDATA=0x1000. Then a word store of 0xABCD to 0x0000 followed by a reload → still 0x1000.
- Word store 0xABCD to 0x2000, then word load 0x2000 → both strobes low together for one cycle; RDATA=0xABCD.
- With 0x3000=0xDCBA: byte store 0xEE to 0x3000 → only WR0N pulses; word load gives 0xDCEE. Restore 0xDCBA, byte store 0xEE to 0x3001 → only WR1N pulses; word load gives 0xEEBA. Byte load 0x3001 → 0x00EE.
- With the macro, 0x3000=0xDCBA and 0x3002=0x0000: word store 0x1234 to 0x3001 → WR1N pulse, then WR0N pulse at ADDR 0x3002. Memory then reads 0x3000=0x34BA and 0x3002=0x0012. Word load 0x3001 → RDATA=0x1234 with ACK 7 cycles after REQ.
- Without the macro, word load 0x3001 → no strobe; ACK=1 and ERR=1 in the next cycle.
- RESET asserted during STROBE of a store → strobes high on the next edge; no ACK; BUSY=0; a following load completes normally.
